// File: rtl/bus_wait_sram.sv
// Word-wide SRAM responder on the pCPU memory bus with a programmable wait-state FSM.
// Optional BUS_RANDWAIT_EN adds 0..3 pseudo-random extra wait cycles per access.
module bus_wait_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_BASE = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_load;
    logic [31:2] a_q;
    logic [31:0] d_q;
    logic        we_q;
    logic        coll_q;
    logic        accept;
    logic        access;
    logic        hit;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    assign hit = (a_q[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign idx = a_q[ADDR_W+1:2];

`ifdef BUS_RANDWAIT_EN
    logic [7:0] lfsr;
    logic [4:0] cnt_sum;

    // Extra wait taken from the LFSR value in force when the request is accepted.
    assign cnt_sum  = {1'b0, CNT_BASE} + {3'b000, lfsr[1:0]};
    assign cnt_load = (cnt_sum > 5'd15) ? 4'd15 : cnt_sum[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'h5A;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign cnt_load = CNT_BASE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd | we) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        access = 1'b0;
        case (state)
            IDLE: begin
                ready  = ~(rd | we);
                accept = rd | we;
            end
            BUSY:    access = (cnt == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'd0;
            spo    <= 32'd0;
            err    <= 1'b0;
            a_q    <= '0;
            d_q    <= 32'd0;
            we_q   <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            err <= access & (~hit | coll_q);
            if (accept) begin
                a_q    <= a[31:2];
                d_q    <= d;
                we_q   <= we;
                coll_q <= rd & we;
                cnt    <= cnt_load;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !we_q) begin
                spo <= hit ? mem[idx] : 32'd0;
            end
        end
    end

    // Reset must also suppress the write so an aborted access leaves RAM intact.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && hit) begin
            mem[idx] <= d_q;
        end
    end

endmodule

// File: tb/tb_bus_wait_sram.sv
// Bench for bus_wait_sram: directed vector table, hand sequences, randomized model check.
module tb_bus_wait_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 0, d = 0, a4 = 0, d4 = 0;
    logic        we = 0, rd = 0, we4 = 0, rd4 = 0;
    logic [31:0] spo, spo4;
    logic        ready, err, ready4, err4;

    int vectors = 0;
    int miscompares = 0;

    bus_wait_sram #(.BASE_ADDR(32'h0), .ADDR_W(12), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .err(err)
    );

    bus_wait_sram #(.BASE_ADDR(32'h0), .ADDR_W(12), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .d(d4), .we(we4), .rd(rd4),
        .spo(spo4), .ready(ready4), .err(err4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] spo;
        bit          err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat, input int w);
        vectors++;
`ifdef BUS_RANDWAIT_EN
        if (lat < w + 1 || lat > w + 4) begin
            miscompares++;
            $display("FAIL %s: latency %0d outside [%0d,%0d]", name, lat, w + 1, w + 4);
        end
`else
        if (lat != w + 1) begin
            miscompares++;
            $display("FAIL %s: latency %0d expected %0d", name, lat, w + 1);
        end
`endif
    endtask

    task automatic drive(input bit sel, input bit r, input bit w,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            rd4 = r; we4 = w; a4 = addr; d4 = data;
        end else begin
            rd = r; we = w; a = addr; d = data;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready4 : ready;
    endfunction

    // One bus access: strobe for a single cycle, then count cycles until ready.
    task automatic access(input bit sel, input bit r, input bit w,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic err_seen);
        @(posedge clk); #1;
        drive(sel, r, w, addr, data);
        #1;
        chk("ready_low_at_request", rdy(sel), 1'b0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, addr, data);
        #1;
        lat = 1;
        while (!rdy(sel) && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        err_seen = sel ? err4 : err;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] mdl [16];
        logic [31:0] spo_m;
        int          reads;
        int          lat_seen;
        int          bad;

        tbl[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0};
        tbl[1]  = '{1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0};
        tbl[2]  = '{0, 1, 32'h0000_0000, 32'h1111_2222, 32'hDEAD_BEEF, 0};
        tbl[3]  = '{1, 0, 32'h0000_4000, 32'h0,         32'h0000_0000, 1};
        tbl[4]  = '{0, 1, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_0000, 1};
        tbl[5]  = '{1, 0, 32'h0000_0000, 32'h0,         32'h1111_2222, 0};
        tbl[6]  = '{1, 1, 32'h0000_0020, 32'h1234_5678, 32'h1111_2222, 1};
        tbl[7]  = '{1, 0, 32'h0000_0020, 32'h0,         32'h1234_5678, 0};
        tbl[8]  = '{0, 1, 32'h0000_3FFC, 32'h0F0F_0F0F, 32'h1234_5678, 0};
        tbl[9]  = '{1, 0, 32'h0000_3FFE, 32'h0,         32'h0F0F_0F0F, 0};
        tbl[10] = '{0, 1, 32'h0000_0030, 32'h1357_9BDF, 32'h0F0F_0F0F, 0};
        tbl[11] = '{1, 0, 32'h0000_0030, 32'h0,         32'h1357_9BDF, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_spo", spo, 32'h0);
        chk("reset_err", err, 1'b0);
        chk("reset_ready4", ready4, 1'b1);

        for (int i = 0; i < 12; i++) begin
            access(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, lat, e);
            chk_lat($sformatf("tbl%0d_lat", i), lat, 1);
            chk($sformatf("tbl%0d_spo", i), spo, tbl[i].spo);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
            @(posedge clk); #2;
            chk($sformatf("tbl%0d_err_cleared", i), err, 1'b0);
        end

        // Reset while a write is still in BUSY: the write must not land.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midbusy_rst_ready", ready, 1'b1);
        chk("midbusy_rst_spo", spo, 32'h0);
        access(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, lat, e);
        chk("midbusy_rst_readback", spo, 32'h1357_9BDF);

        // Four-wait-state instance: exact latency and hold of read data.
        access(1, 1'b0, 1'b1, 32'h0000_0040, 32'h55AA_55AA, lat, e);
        chk_lat("w4_write_lat", lat, 4);
        access(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, e);
        chk_lat("w4_read_lat", lat, 4);
        chk("w4_read_spo", spo4, 32'h55AA_55AA);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (spo4 !== 32'h55AA_55AA || ready4 !== 1'b1) bad++;
        end
        chk("w4_spo_hold_cycles_bad", bad, 0);

        // Randomized traffic against a simple word-array model.
        for (int k = 0; k < 16; k++) begin
            mdl[k] = $urandom;
            access(0, 1'b0, 1'b1, 32'h100 + 32'(k * 4), mdl[k], lat, e);
        end
        spo_m    = 32'h1357_9BDF;
        reads    = 0;
        lat_seen = 0;
        for (int n = 0; n < 200; n++) begin
            int          k;
            int          opsel;
            bit          miss;
            bit          r, w;
            logic [31:0] addr, data;
            k     = $urandom_range(0, 15);
            opsel = $urandom_range(0, 4);
            miss  = ($urandom_range(0, 9) == 0);
            r     = (opsel != 1);
            w     = (opsel == 1 || opsel == 4);
            addr  = (miss ? 32'h0001_0000 : 32'h0) + 32'h100 + 32'(k * 4) + 32'($urandom_range(0, 3));
            data  = $urandom;
            access(0, r, w, addr, data, lat, e);
            if (w) begin
                if (!miss) mdl[k] = data;
            end else begin
                spo_m = miss ? 32'h0 : mdl[k];
                reads++;
                if (lat >= 0 && lat < 31) lat_seen |= (1 << lat);
            end
            chk_lat($sformatf("rand%0d_lat", n), lat, 1);
            chk($sformatf("rand%0d_spo", n), spo, spo_m);
            chk($sformatf("rand%0d_err", n), e, miss || (r && w));
        end
`ifdef BUS_RANDWAIT_EN
        chk("rand_reads_at_least_64", reads >= 64, 1'b1);
        chk("rand_distinct_latencies_ge3", $countones(lat_seen) >= 3, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
